// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types for the program image loader.
// Loader FSM states and the default first load address.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        RELEASE,
        RUN
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0020;

endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: small synchronous write buffer for the program loader.
// Head comes straight from the storage registers; a push is visible next cycle.
module loader_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [DATA_W-1:0]       head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
    localparam logic [PW:0] FULL_N  = (PW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer bit separates full from empty
    assign count   = wr_ptr - rd_ptr;
    assign full    = count == FULL_N;
    assign empty   = wr_ptr == rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a program image into instruction memory, then releases cpu reset.
// Define PROG_LOADER_CHECKSUM_EN to treat the in_last word as a payload checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
    parameter int                MAX_WORDS  = 256,
    parameter int                FIFO_DEPTH = 4,
    parameter int                RESET_HOLD = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic                           mem_ready,
    output logic                           cpu_reset,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_count,
    output logic                           overflow_err,
    output logic                           chk_err
);

    localparam int WC_W = $clog2(MAX_WORDS+1);
    localparam int HC_W = $clog2(RESET_HOLD+1);
    localparam int FC_W = $clog2(FIFO_DEPTH)+1;
    localparam logic [WC_W-1:0]   WC_ONE    = WC_W'(1);
    localparam logic [HC_W-1:0]   HC_ONE    = HC_W'(1);
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(RESET_HOLD-1);
    localparam logic [FC_W-1:0]   FC_ONE    = FC_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            next;
    logic [WC_W-1:0]   in_count;
    logic [HC_W-1:0]   hold_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [FC_W-1:0]   fifo_count;
    logic              load_start;
    logic              accept;
    logic              push;
    logic              pop;
    logic              to_drain;
    logic              ovf_set;
    logic              drained;

    assign load_start = start && (state == IDLE || state == RUN);
    assign in_ready   = state == LOAD && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign mem_we     = (state == LOAD || state == DRAIN) && !fifo_empty;
    assign mem_wdata  = mem_we ? fifo_head : '0;
    assign pop        = mem_we && mem_ready;
    assign drained    = fifo_empty || (pop && fifo_count == FC_ONE);
    assign cpu_reset  = state != RUN;
    assign busy       = state == LOAD || state == DRAIN || state == RELEASE;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [WC_W-1:0] CAP = WC_W'(MAX_WORDS);

    logic [DATA_W-1:0] sum;
    logic              chk_q;
    logic              chk_set;

    // A full payload may still be followed by its checksum word
    assign push     = accept && !in_last && in_count != CAP;
    assign to_drain = accept && (in_last || in_count == CAP);
    assign ovf_set  = accept && !in_last && in_count == CAP;
    assign chk_set  = accept && in_last && sum != in_data;
    assign chk_err  = chk_q;

    always_ff @(posedge clk) begin
        if (reset || load_start) begin
            sum   <= '0;
            chk_q <= 1'b0;
        end else begin
            if (push)    sum   <= sum + in_data;
            if (chk_set) chk_q <= 1'b1;
        end
    end
`else
    localparam logic [WC_W-1:0] CAP_M1 = WC_W'(MAX_WORDS-1);

    assign push     = accept;
    assign to_drain = accept && (in_last || in_count == CAP_M1);
    assign ovf_set  = accept && !in_last && in_count == CAP_M1;
    assign chk_err  = 1'b0;
`endif

    loader_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (load_start),
        .push     (push),
        .push_data(in_data),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (start) next = LOAD;
            LOAD:    if (to_drain) next = DRAIN;
            DRAIN:   if (drained) next = chk_err ? IDLE : RELEASE;
            RELEASE: if (hold_cnt == HOLD_LAST) next = RUN;
            RUN:     if (start) next = LOAD;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mem_addr     <= BASE_ADDR;
            word_count   <= '0;
            in_count     <= '0;
            overflow_err <= 1'b0;
            hold_cnt     <= '0;
            done         <= 1'b0;
        end else begin
            state    <= next;
            done     <= state == RELEASE && next == RUN;
            hold_cnt <= (state == RELEASE) ? hold_cnt + HC_ONE : '0;
            if (load_start) begin
                mem_addr     <= BASE_ADDR;
                word_count   <= '0;
                in_count     <= '0;
                overflow_err <= 1'b0;
            end else begin
                if (pop) begin
                    mem_addr   <= mem_addr + ADDR_ONE;
                    word_count <= word_count + WC_ONE;
                end
                if (push)    in_count     <= in_count + WC_ONE;
                if (ovf_set) overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vectors for the program image loader.
// A default instance and a 4-word-limit instance share the input stimulus.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        mem_ready;

    logic        in_ready, mem_we, cpu_reset, busy, done;
    logic        overflow_err, chk_err;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [8:0]  word_count;

    logic        o_in_ready, o_mem_we, o_cpu_reset, o_busy, o_done;
    logic        o_overflow_err, o_chk_err;
    logic [31:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic [2:0]  o_word_count;

    always #5 clk = ~clk;

    prog_loader u_dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .cpu_reset(cpu_reset), .busy(busy), .done(done),
        .word_count(word_count), .overflow_err(overflow_err),
        .chk_err(chk_err)
    );

    prog_loader #(.MAX_WORDS(4)) u_ovf (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(o_in_ready), .mem_we(o_mem_we), .mem_addr(o_mem_addr),
        .mem_wdata(o_mem_wdata), .mem_ready(mem_ready),
        .cpu_reset(o_cpu_reset), .busy(o_busy), .done(o_done),
        .word_count(o_word_count), .overflow_err(o_overflow_err),
        .chk_err(o_chk_err)
    );

    typedef struct {
        logic        st;
        logic        v;
        logic        last;
        logic [15:0] d;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic [15:0] wd;
        logic        cr;
        logic        bsy;
        logic        dn;
        logic [8:0]  wc;
    } vec_t;

    vec_t        tbl [11];
    logic [31:0] la [$];
    logic [15:0] ld [$];
    logic [31:0] oa [$];
    logic [15:0] od [$];
    logic [15:0] img [$];
    int          checks = 0;
    int          errors = 0;
    int          dn_cnt = 0;
    int          last_idx = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Log completed writes, then advance to the next falling edge
    task automatic tick(input bit sel, output bit acc);
        if (mem_we && mem_ready) begin
            la.push_back(mem_addr);
            ld.push_back(mem_wdata);
        end
        if (o_mem_we && mem_ready) begin
            oa.push_back(o_mem_addr);
            od.push_back(o_mem_wdata);
        end
        if (done) dn_cnt++;
        acc = in_valid && (sel ? o_in_ready : in_ready);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bit a;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_last = 1'b0; in_data = '0; mem_ready = 1'b1;
        tick(1'b0, a);
        tick(1'b0, a);
        reset = 1'b0;
    endtask

    task automatic check_log(input string nm, input bit sel, input int n);
        int sz;
        sz = sel ? oa.size() : la.size();
        chk({nm, "_count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            chk({nm, "_addr"}, sel ? oa[i] : la[i], 32'h20 + 32'(i));
            chk({nm, "_data"}, 32'(sel ? od[i] : ld[i]), 32'(img[i]));
        end
    endtask

    task automatic run_image(input int n, input bit use_last, input bit sel,
                             input int st_lo, input int st_hi, input bit bp);
        int idx;
        int cyc;
        bit acc;
        idx = 0;
        la.delete(); ld.delete(); oa.delete(); od.delete();
        start = 1'b1; mem_ready = 1'b1;
        tick(sel, acc);
        start = 1'b0;
        chk("start_cpu_reset", 32'(sel ? o_cpu_reset : cpu_reset), 32'd1);
        for (cyc = 1; cyc < 300; cyc++) begin
            if (!(sel ? o_busy : busy)) break;
            in_valid  = idx < n;
            in_data   = (idx < n) ? img[idx] : 16'h0;
            in_last   = use_last && (idx == n - 1);
            mem_ready = !(cyc >= st_lo && cyc <= st_hi);
            if (bp && cyc == 5) chk("bp_ready_open", 32'(in_ready), 32'd1);
            if (bp && cyc >= 6 && cyc <= 8) begin
                chk("bp_ready_full", 32'(in_ready), 32'd0);
                chk("bp_addr_hold", mem_addr, 32'h21);
                chk("bp_data_hold", 32'(mem_wdata), 32'(img[1]));
            end
            tick(sel, acc);
            if (acc) idx++;
        end
        in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
        if (cyc >= 300) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: still busy after %0d cycles", cyc);
        end
        last_idx = idx;
    endtask

    initial begin
        bit a;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_last = 1'b0; in_data = '0; mem_ready = 1'b1;
        @(negedge clk);
        do_reset();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h20);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_overflow", 32'(overflow_err), 32'd0);
        chk("rst_chk_err", 32'(chk_err), 32'd0);

`ifndef PROG_LOADER_CHECKSUM_EN
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0, 32'h20,
                    16'h0000, 1'b1, 1'b0, 1'b0, 9'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h0F7F, 1'b1, 1'b0, 32'h20,
                    16'h0000, 1'b1, 1'b1, 1'b0, 9'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'h975F, 1'b1, 1'b1, 32'h20,
                    16'h0F7F, 1'b1, 1'b1, 1'b0, 9'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h631F, 1'b1, 1'b1, 32'h21,
                    16'h975F, 1'b1, 1'b1, 1'b0, 9'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h1F3D, 1'b1, 1'b1, 32'h22,
                    16'h631F, 1'b1, 1'b1, 1'b0, 9'd2};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h1F3D, 1'b1, 1'b1, 32'h23,
                    16'h1F3D, 1'b1, 1'b1, 1'b0, 9'd3};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h24,
                    16'h1F3D, 1'b1, 1'b1, 1'b0, 9'd4};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h25,
                    16'h0000, 1'b1, 1'b1, 1'b0, 9'd5};
        tbl[8]  = tbl[7];
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h25,
                    16'h0000, 1'b0, 1'b0, 1'b1, 9'd5};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h25,
                    16'h0000, 1'b0, 1'b0, 1'b0, 9'd5};

        la.delete(); ld.delete();
        for (int i = 0; i < 11; i++) begin
            start    = tbl[i].st;
            in_valid = tbl[i].v;
            in_last  = tbl[i].last;
            in_data  = tbl[i].d;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].wd));
            chk($sformatf("tbl%0d_cpu_reset", i), 32'(cpu_reset), 32'(tbl[i].cr));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("tbl%0d_word_count", i), 32'(word_count), 32'(tbl[i].wc));
            tick(1'b0, a);
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        img = '{16'h0F7F, 16'h975F, 16'h631F, 16'h1F3D, 16'h1F3D};
        check_log("basic", 1'b0, 5);

        img = '{16'h1234, 16'hABCD};
        run_image(2, 1'b1, 1'b0, 0, -1, 1'b0);
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("reload_done", 32'(done), 32'd1);
        check_log("reload", 1'b0, 2);
        tick(1'b0, a);
        chk("reload_done_once", 32'(done), 32'd0);

        img = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                16'h5555, 16'h6666, 16'h7777, 16'h8888};
        run_image(8, 1'b1, 1'b0, 3, 8, 1'b1);
        check_log("bp", 1'b0, 8);
        chk("bp_word_count", 32'(word_count), 32'd8);

        do_reset();
        img = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006};
        run_image(6, 1'b0, 1'b1, 0, -1, 1'b0);
        chk("ovf_accepted", 32'(last_idx), 32'd4);
        chk("ovf_flag", 32'(o_overflow_err), 32'd1);
        chk("ovf_in_ready", 32'(o_in_ready), 32'd0);
        chk("ovf_cpu_reset", 32'(o_cpu_reset), 32'd0);
        chk("ovf_word_count", 32'(o_word_count), 32'd4);
        check_log("ovf", 1'b1, 4);

        run_image(4, 1'b1, 1'b1, 0, -1, 1'b0);
        chk("cap_last_no_ovf", 32'(o_overflow_err), 32'd0);
        chk("cap_cpu_reset", 32'(o_cpu_reset), 32'd0);
        check_log("cap", 1'b1, 4);

        do_reset();
        img = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005};
        start = 1'b1;
        tick(1'b0, a);
        start = 1'b0;
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 30 && word_count != 9'd2; c++) begin
                in_valid = idx < 5;
                in_data  = (idx < 5) ? img[idx] : 16'h0;
                in_last  = idx == 4;
                tick(1'b0, a);
                if (a) idx++;
            end
        end
        chk("mid_two_written", 32'(word_count), 32'd2);
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        tick(1'b0, a);
        reset = 1'b0;
        chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_mem_we", 32'(mem_we), 32'd0);
        chk("mid_word_count", 32'(word_count), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        chk("mid_mem_addr", mem_addr, 32'h20);
        img = '{16'hD001, 16'hD002, 16'hD003};
        run_image(3, 1'b1, 1'b0, 0, -1, 1'b0);
        chk("mid_reload_run", 32'(cpu_reset), 32'd0);
        check_log("mid_reload", 1'b0, 3);
        chk("chk_err_tied", 32'(chk_err), 32'd0);
`else
        img = '{16'h0001, 16'h0002, 16'h0003};
        run_image(3, 1'b1, 1'b0, 0, -1, 1'b0);
        chk("ck_ok_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("ck_ok_done", 32'(done), 32'd1);
        chk("ck_ok_chk_err", 32'(chk_err), 32'd0);
        check_log("ck_ok", 1'b0, 2);
        tick(1'b0, a);

        img = '{16'h0001, 16'h0002, 16'h0004};
        dn_cnt = 0;
        run_image(3, 1'b1, 1'b0, 0, -1, 1'b0);
        chk("ck_bad_chk_err", 32'(chk_err), 32'd1);
        chk("ck_bad_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("ck_bad_idle", 32'(busy), 32'd0);
        check_log("ck_bad", 1'b0, 2);
        for (int i = 0; i < 4; i++) tick(1'b0, a);
        chk("ck_bad_no_done", 32'(dn_cnt), 32'd0);
        chk("ck_bad_hold_reset", 32'(cpu_reset), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Streams a program image into instruction memory through a valid/ready input and a buffered memory write port, then releases the processor from reset.
- Replaces the hand-sequenced write_enable_fm/write_addr_fm/write_data_fm plus reset-pulse loading with a self-timed block.
- Sits between the host/bench loader and the instruction-memory write port and processor reset of pipelinedProcessor.

Parameters:
- DATA_W, 16, instruction word width
- ADDR_W, 32, memory address width
- BASE_ADDR, 32, first load address (0x20)
- MAX_WORDS, 256, image size limit
- FIFO_DEPTH, 4, write buffer depth (power of 2, ≥2)
- RESET_HOLD, 2, cycles cpu_reset stays high after the last write completes (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a load (accepted in IDLE or RUN)
- in_valid  in  1  input word valid
- in_data  in  DATA_W  input word
- in_last  in  1  marks final word of image
- in_ready  out  1  input accepted when in_valid && in_ready
- mem_we  out  1  memory write request
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  write completes when mem_we && mem_ready
- cpu_reset  out  1  processor reset
- busy  out  1  high in LOAD/DRAIN/RELEASE
- done  out  1  one-cycle pulse on entering RUN
- word_count  out  $clog2(MAX_WORDS+1)  words written this load
- overflow_err  out  1  sticky; image exceeded MAX_WORDS
- chk_err  out  1  sticky checksum mismatch (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-load): state=IDLE, cpu_reset=1, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, word_count=0, overflow_err=0, chk_err=0, FIFO empty. Words already written stay in memory.
- FSM states: IDLE, LOAD, DRAIN, RELEASE, RUN.
- IDLE: cpu_reset=1. start -> LOAD; clear word_count, errors and FIFO; mem_addr=BASE_ADDR.
- LOAD:
  - in_ready = !fifo_full. No same-cycle bypass: a full FIFO blocks the push even if a pop occurs that cycle.
  - An accepted word enters the FIFO. mem_we is asserted no earlier than the cycle after acceptance (registered FIFO, one-cycle minimum latency).
  - Accepting in_last, or the MAX_WORDS-th word, -> DRAIN.
  - Reaching MAX_WORDS without in_last sets overflow_err. Later input is refused (in_ready=0) until the next start.
- Write port:
  - mem_we = !fifo_empty in LOAD/DRAIN; mem_wdata = FIFO head.
  - On mem_we && mem_ready: pop, mem_addr+1 (wraps modulo 2^ADDR_W), word_count+1.
  - mem_we/addr/data hold stable while mem_ready=0.
- DRAIN: in_ready=0. FIFO empty with no write pending -> RELEASE.
- RELEASE: cpu_reset=1 for exactly RESET_HOLD cycles, then -> RUN.
- RUN: cpu_reset=0; done=1 for the first RUN cycle only. start -> LOAD, and cpu_reset returns to 1 the next cycle (reload).
- start is ignored in LOAD, DRAIN and RELEASE.
- If start and in_valid arrive together in IDLE, the word is not accepted that cycle.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- With the macro:
  - The in_last word is a checksum and is not written to memory.
  - The payload sum modulo 2^DATA_W is compared against it.
  - Mismatch: set chk_err, return to IDLE after DRAIN, skip RELEASE/RUN, no done pulse, cpu_reset stays 1.
  - MAX_WORDS counts payload words only.
- Without the macro: in_last is an ordinary payload word and chk_err is tied to 0.

Decomposition:
- prog_loader_pkg: state enum (IDLE/LOAD/DRAIN/RELEASE/RUN) and a default-BASE_ADDR localparam.
- One sub-module, loader_fifo: synchronous FIFO parametrised by DATA_W/FIFO_DEPTH, with full/empty flags and a registered head.

Test Plan:
- Basic load: start, 5 words (0x0F7F, 0x975F, 0x631F, 0x1F3D, 0x1F3D, last on 5th), mem_ready=1.
  - Writes to 0x20..0x24, word_count=5.
  - cpu_reset falls RESET_HOLD=2 cycles after the last write; done pulses once.
- Backpressure: mem_ready=0 for 6 cycles mid-image with continuous in_valid.
  - in_ready drops after 4 buffered words; mem_addr/data stay stable.
  - No loss or duplication; all 8 words written in order.
- Overflow: MAX_WORDS=4, send 6 words with no in_last.
  - 4 words written, overflow_err=1, in_ready=0, RUN reached.
- Reset mid-load: assert reset after 2 of 5 writes.
  - Next cycle: IDLE, cpu_reset=1, mem_we=0, word_count=0.
  - A new start reloads from 0x20.
- Reload from RUN: start in RUN.
  - cpu_reset=1 the next cycle; second image written from 0x20; done pulses again.
- Checksum (PROG_LOADER_CHECKSUM_EN): payload 0x0001, 0x0002.
  - Checksum 0x0003: 2 writes, RUN reached.
  - Checksum 0x0004: chk_err=1, back to IDLE, cpu_reset=1, no done.
